// File: rtl/gate_bist_checker.sv
// gate_bist_checker: BIST sweep of all four 2-input vectors into a gate, checked against TRUTH_TABLE.
// Optional ERROR_LOG_EN adds failMask, a per-vector record of mismatches across the run.
module gate_bist_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         PASSES        = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       abort,
    output logic       input1,
    output logic       input2,
    input  logic       result,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] failCount,
    output logic       firstFailValid,
    output logic [1:0] firstFailVector
`ifdef ERROR_LOG_EN
    ,
    output logic [3:0] failMask
`endif
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [3:0] S_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] P_LAST = 4'(PASSES - 1);
    localparam bit HAS_SETTLE = SETTLE_CYCLES > 0;
    logic [2:0] state;
    logic [1:0] vec;
    logic [3:0] scnt;
    logic [3:0] pcnt;
    logic       mismatch;
    assign mismatch = result != TRUTH_TABLE[vec];
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            vec             <= 2'd0;
            scnt            <= 4'd0;
            pcnt            <= 4'd0;
            input1          <= 1'b0;
            input2          <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            failCount       <= 6'd0;
            firstFailValid  <= 1'b0;
            firstFailVector <= 2'd0;
`ifdef ERROR_LOG_EN
            failMask        <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            // DONE ignores abort so a completed run always reports
            if (abort && state != IDLE && state != DONE) begin
                state  <= IDLE;
                input1 <= 1'b0;
                input2 <= 1'b0;
                pass   <= 1'b0;
                scnt   <= 4'd0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        state           <= DRIVE;
                        vec             <= 2'd0;
                        pcnt            <= 4'd0;
                        pass            <= 1'b0;
                        failCount       <= 6'd0;
                        firstFailValid  <= 1'b0;
                        firstFailVector <= 2'd0;
`ifdef ERROR_LOG_EN
                        failMask        <= 4'd0;
`endif
                    end
                    DRIVE: begin
                        input1 <= vec[0];
                        input2 <= vec[1];
                        scnt   <= 4'd0;
                        state  <= HAS_SETTLE ? SETTLE : SAMPLE;
                    end
                    SETTLE: begin
                        scnt  <= scnt + 4'd1;
                        state <= (scnt == S_LAST) ? SAMPLE : SETTLE;
                    end
                    SAMPLE: begin
                        if (mismatch) begin
                            failCount <= failCount + {5'd0, failCount != 6'd63};
`ifdef ERROR_LOG_EN
                            failMask[vec] <= 1'b1;
`endif
                            if (!firstFailValid) begin
                                firstFailValid  <= 1'b1;
                                firstFailVector <= vec;
                            end
                        end
                        if (vec != 2'd3) begin
                            vec   <= vec + 2'd1;
                            state <= DRIVE;
                        end else if (pcnt != P_LAST) begin
                            vec   <= 2'd0;
                            pcnt  <= pcnt + 4'd1;
                            state <= DRIVE;
                        end else begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        pass  <= failCount == 6'd0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb_gate_bist_checker: three checker instances (varied settle/passes) against a cycle-count reference model.
module tb_gate_bist_checker;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [3:0] gt = 4'b0111;
    logic [2:0] i1, i2, res, busy, done, pass, ffv;
    logic [5:0] fc [3];
    logic [1:0] fvec [3];
    logic [3:0] fm [3];
    int checks = 0;
    int errors = 0;
    int dc [3];
    localparam logic [3:0] TT = 4'b0111;
    localparam int SV [3] = '{2, 0, 1};
    localparam int PV [3] = '{1, 1, 2};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign res[g] = gt[{i2[g], i1[g]}];
        gate_bist_checker #(
            .TRUTH_TABLE(TT),
            .SETTLE_CYCLES(g == 0 ? 2 : g == 1 ? 0 : 1),
            .PASSES(g == 2 ? 2 : 1)
        ) u_dut (
            .clk(clk),
            .resetN(resetN),
            .start(start),
            .abort(abort),
            .input1(i1[g]),
            .input2(i2[g]),
            .result(res[g]),
            .busy(busy[g]),
            .done(done[g]),
            .pass(pass[g]),
            .failCount(fc[g]),
            .firstFailValid(ffv[g]),
`ifdef ERROR_LOG_EN
            .failMask(fm[g]),
`endif
            .firstFailVector(fvec[g])
        );
`ifndef ERROR_LOG_EN
        assign fm[g] = 4'd0;
`endif
    end

    // Reference: position in the run is just edges elapsed since the accepted start.
    logic [1:0] m_in [3] = '{2'd0, 2'd0, 2'd0};
    logic [5:0] m_fc [3] = '{6'd0, 6'd0, 6'd0};
    logic [1:0] m_fv [3] = '{2'd0, 2'd0, 2'd0};
    logic [3:0] m_mask [3] = '{4'd0, 4'd0, 4'd0};
    logic [2:0] m_run = 3'd0, m_done = 3'd0, m_pass = 3'd0, m_ffv = 3'd0;
    int m_t [3] = '{0, 0, 0};
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_run = 0; m_done = 0; m_pass = 0; m_ffv = 0;
            for (int i = 0; i < 3; i++) begin
                m_in[i] = 0; m_fc[i] = 0; m_fv[i] = 0; m_mask[i] = 0; m_t[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int len, tot, p, v;
                len = SV[i] + 2;
                tot = 4 * PV[i] * len;
                m_done[i] = 1'b0;
                if (!m_run[i]) begin
                    if (start && !abort) begin
                        m_run[i] = 1; m_t[i] = 0; m_fc[i] = 0; m_ffv[i] = 0;
                        m_fv[i] = 0; m_pass[i] = 0; m_mask[i] = 0;
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] == tot + 1) begin
                        m_done[i] = 1; m_pass[i] = m_fc[i] == 0; m_run[i] = 0;
                    end else if (abort) begin
                        m_run[i] = 0; m_in[i] = 0; m_pass[i] = 0;
                    end else begin
                        p = m_t[i] - 1;
                        v = (p / len) % 4;
                        if (p % len == 0) m_in[i] = 2'(v);
                        if (p % len == len - 1 && gt[v] != TT[v]) begin
                            if (m_fc[i] < 63) m_fc[i]++;
                            if (!m_ffv[i]) begin m_ffv[i] = 1; m_fv[i] = 2'(v); end
                            m_mask[i][v] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [13:0] a, e;
            a = {i2[i], i1[i], busy[i], done[i], pass[i], fc[i], ffv[i], fvec[i]};
            e = {m_in[i], m_run[i], m_done[i], m_pass[i], m_fc[i], m_ffv[i], m_fv[i]};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL u%0d outputs {in,busy,done,pass,fc,ffv,fvec}: got %h want %h at %0t", i, a, e, $time);
            end
`ifdef ERROR_LOG_EN
            checks++;
            if (fm[i] !== m_mask[i]) begin
                errors++;
                $display("FAIL u%0d failMask: got %b want %b at %0t", i, fm[i], m_mask[i], $time);
            end
`endif
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic go(input int maxc, input int abort_at, input int restart_at, input bit seq);
        dc = '{0, 0, 0};
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int k = 1; k <= maxc; k++) begin
            abort = k == abort_at;
            start = k == restart_at;
            @(posedge clk); #2;
            abort = 1'b0;
            start = 1'b0;
            for (int i = 0; i < 3; i++) if (done[i] && dc[i] == 0) dc[i] = k;
            if (seq && k % 4 == 2 && k < 16) chk("u0 vector", int'({i2[0], i1[0]}), k / 4);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 resetN = 1'b1;
        chk("reset busy", int'(busy), 0);
        chk("reset fc", int'(fc[0]), 0);
        // correct NAND, mid-run start re-pulse must not disturb anything
        gt = 4'b0111;
        go(30, 0, 3, 1);
        chk("u0 done cycle", dc[0], 17);
        chk("u1 done cycle", dc[1], 9);
        chk("u2 done cycle", dc[2], 25);
        chk("u0 pass", int'(pass[0]), 1);
        chk("u0 ffv", int'(ffv[0]), 0);
        // AND instead of NAND: every vector wrong
        gt = 4'b1000;
        go(30, 0, 0, 0);
        chk("and u2 fc", int'(fc[2]), 8);
        chk("and u2 fvec", int'(fvec[2]), 0);
        chk("and u2 pass", int'(pass[2]), 0);
        chk("and u0 fc", int'(fc[0]), 4);
`ifdef ERROR_LOG_EN
        chk("and u2 mask", int'(fm[2]), 15);
`endif
        // stuck-at-1 output: only vector 3 differs
        gt = 4'b1111;
        go(30, 0, 0, 0);
        chk("sa1 u0 fc", int'(fc[0]), 1);
        chk("sa1 u0 fvec", int'(fvec[0]), 3);
        chk("sa1 u0 pass", int'(pass[0]), 0);
`ifdef ERROR_LOG_EN
        chk("sa1 u0 mask", int'(fm[0]), 8);
`endif
        // abort in second SETTLE of u0, then a clean run
        gt = 4'b0111;
        go(30, 6, 0, 0);
        chk("abort u0 no done", dc[0], 0);
        chk("abort u0 pass", int'(pass[0]), 0);
        chk("abort u0 inputs", int'({i2[0], i1[0]}), 0);
        go(30, 0, 0, 0);
        chk("post-abort u0 done", dc[0], 17);
        chk("post-abort u0 pass", int'(pass[0]), 1);
        // abort landing on u1's DONE cycle leaves its report intact
        go(30, 9, 0, 0);
        chk("abort-in-done u1 done", dc[1], 9);
        chk("abort-in-done u1 pass", int'(pass[1]), 1);
        chk("abort-in-done u0 no done", dc[0], 0);
        // async reset in the middle of u0's first SAMPLE
        gt = 4'b1000;
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        chk("async rst busy", int'(busy), 0);
        chk("async rst inputs", int'({i2, i1}), 0);
        chk("async rst fc", int'(fc[0]), 0);
        @(posedge clk); #2 resetN = 1'b1;
        gt = 4'b0111;
        go(30, 0, 0, 0);
        chk("post-reset u0 pass", int'(pass[0]), 1);
        chk("post-reset u2 pass", int'(pass[2]), 1);
        for (int r = 0; r < 40; r++) begin
            gt = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0111;
            repeat ($urandom_range(0, 3)) begin
                start = 1'b1;
                abort = 1'b1;
                @(posedge clk); #2;
                start = 1'b0;
                abort = 1'b0;
            end
            go(30, ($urandom % 3 == 0) ? $urandom_range(9, 30) : 0, $urandom_range(0, 8), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
